// File: rtl/bit_unstuff_down_if.sv
// Bit-level link between the sync/EOP detector, the bit unstuffer and the
// downstream packet decoder.
interface bit_unstuff_down_if;
  logic line_in;
  logic line_valid;
  logic sync_done;
  logic pkt_done;
  logic bit_out;
  logic bit_valid;
  logic stuff_err;
  logic err_flag;
  logic in_pkt;

  modport master (
    output line_in, line_valid, sync_done, pkt_done,
    input  bit_out, bit_valid, stuff_err, err_flag, in_pkt
  );

  modport slave (
    input  line_in, line_valid, sync_done, pkt_done,
    output bit_out, bit_valid, stuff_err, err_flag, in_pkt
  );
endinterface

// File: rtl/bit_unstuff_down.sv
// Receive-side NRZI decoder and bit unstuffer: drops the zero that follows
// every STUFF_LEN decoded ones and flags a one found in that position.
//
//   state | meaning
//   IDLE  | waiting for sync_done, line samples only tracked for NRZI
//   RECV  | decoding and unstuffing packet bits
//   ERR   | stuffing violation seen, bits ignored until EOP or resync
module bit_unstuff_down #(
  parameter int STUFF_LEN = 6
) (
  input  logic               clk,
  input  logic               reset,
  bit_unstuff_down_if.slave  bus
);

  localparam int CW = $clog2(STUFF_LEN + 1);
  localparam logic [CW-1:0] STUFF_CNT = CW'(STUFF_LEN);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_line_q, prev_line_d;
  logic          bit_out_q, bit_out_d;
  logic          bit_valid_q, bit_valid_d;
  logic          stuff_err_q, stuff_err_d;
  logic          err_flag_q, err_flag_d;
  logic          in_pkt_q, in_pkt_d;
  logic          dec_bit;

  // NRZI: no transition decodes as one
  assign dec_bit = ~(bus.line_in ^ prev_line_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prev_line_d = bus.line_valid ? bus.line_in : prev_line_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    stuff_err_d = 1'b0;
    err_flag_d  = err_flag_q;

    if (bus.sync_done) begin
      // the final sync bit is a one and counts toward the first stuff run
      state_d    = RECV;
      cnt_d      = CNT_ONE;
      err_flag_d = 1'b0;
    end else if (bus.pkt_done && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: cnt_d = '0;
        RECV: begin
          if (bus.line_valid) begin
            if (cnt_q < STUFF_CNT) begin
              bit_out_d   = dec_bit;
              bit_valid_d = 1'b1;
              cnt_d       = dec_bit ? (cnt_q + CNT_ONE) : '0;
            end else if (!dec_bit) begin
              cnt_d = '0;
            end else begin
              stuff_err_d = 1'b1;
              err_flag_d  = 1'b1;
              state_d     = ERR;
            end
          end
        end
        ERR:     ;
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    in_pkt_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prev_line_q <= 1'b1;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      stuff_err_q <= 1'b0;
      err_flag_q  <= 1'b0;
      in_pkt_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_line_q <= prev_line_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      stuff_err_q <= stuff_err_d;
      err_flag_q  <= err_flag_d;
      in_pkt_q    <= in_pkt_d;
    end
  end

  assign bus.bit_out   = bit_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.stuff_err = stuff_err_q;
  assign bus.err_flag  = err_flag_q;
  assign bus.in_pkt    = in_pkt_q;

endmodule

// File: tb/tb_bit_unstuff_down.sv
// Directed bench for bit_unstuff_down: unstuffing, stuff errors, NRZI decode,
// EOP priority and asynchronous reset.
module tb_bit_unstuff_down;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic lvl;
  logic bv, bo, se;

  bit_unstuff_down_if bus ();

  bit_unstuff_down #(.STUFF_LEN(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_raw(input logic l, output logic o_bv, output logic o_bo, output logic o_se);
    @(negedge clk);
    bus.line_in    = l;
    bus.line_valid = 1'b1;
    @(negedge clk);
    bus.line_valid = 1'b0;
    o_bv = bus.bit_valid;
    o_bo = bus.bit_out;
    o_se = bus.stuff_err;
    lvl  = l;
  endtask

  task automatic send_dec(input logic d, output logic o_bv, output logic o_bo, output logic o_se);
    send_raw(d ? lvl : ~lvl, o_bv, o_bo, o_se);
  endtask

  task automatic do_sync();
    @(negedge clk);
    bus.line_in    = lvl;
    bus.line_valid = 1'b1;
    bus.sync_done  = 1'b1;
    @(negedge clk);
    bus.line_valid = 1'b0;
    bus.sync_done  = 1'b0;
  endtask

  task automatic do_eop();
    @(negedge clk);
    bus.pkt_done = 1'b1;
    @(negedge clk);
    bus.pkt_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.bit_valid !== 1'b0 || bus.stuff_err !== 1'b0 || bus.err_flag !== 1'b0 ||
        bus.in_pkt !== 1'b0 || bus.bit_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got bv=%b se=%b ef=%b ip=%b bo=%b, want all 0",
               bus.bit_valid, bus.stuff_err, bus.err_flag, bus.in_pkt, bus.bit_out);
    end
    reset = 1'b0;
    @(negedge clk);
    send_raw(1'b0, bv, bo, se);
    n_checks++;
    if (bv !== 1'b0 || bus.in_pkt !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignore: got bv=%b in_pkt=%b, want 0 0", bv, bus.in_pkt);
    end
  endtask

  task automatic test_unstuff();
    int emitted;
    emitted = 0;
    do_sync();
    n_checks++;
    if (bus.in_pkt !== 1'b1 || bus.bit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_entry: got in_pkt=%b bv=%b, want 1 0", bus.in_pkt, bus.bit_valid);
    end
    for (int i = 0; i < 5; i++) begin
      send_dec(1'b1, bv, bo, se);
      if (bv === 1'b1) emitted++;
      n_checks++;
      if (bv !== 1'b1 || bo !== 1'b1) begin
        n_fail++;
        $display("FAIL unstuff_one[%0d]: got bv=%b bo=%b, want 1 1", i, bv, bo);
      end
    end
    send_dec(1'b0, bv, bo, se);
    if (bv === 1'b1) emitted++;
    n_checks++;
    if (bv !== 1'b0 || se !== 1'b0) begin
      n_fail++;
      $display("FAIL unstuff_drop: got bv=%b se=%b, want 0 0", bv, se);
    end
    send_dec(1'b1, bv, bo, se);
    if (bv === 1'b1) emitted++;
    n_checks++;
    if (bv !== 1'b1 || bo !== 1'b1) begin
      n_fail++;
      $display("FAIL unstuff_after: got bv=%b bo=%b, want 1 1", bv, bo);
    end
    n_checks++;
    if (emitted != 6) begin
      n_fail++;
      $display("FAIL unstuff_count: got %0d bits, want 6", emitted);
    end
    do_eop();
  endtask

  task automatic test_stuff_error();
    do_sync();
    for (int i = 0; i < 5; i++) begin
      send_dec(1'b1, bv, bo, se);
      n_checks++;
      if (bv !== 1'b1 || bo !== 1'b1 || se !== 1'b0) begin
        n_fail++;
        $display("FAIL err_pre[%0d]: got bv=%b bo=%b se=%b, want 1 1 0", i, bv, bo, se);
      end
    end
    send_dec(1'b1, bv, bo, se);
    n_checks++;
    if (bv !== 1'b0 || se !== 1'b1 || bus.err_flag !== 1'b1 || bus.in_pkt !== 1'b1) begin
      n_fail++;
      $display("FAIL err_hit: got bv=%b se=%b ef=%b ip=%b, want 0 1 1 1",
               bv, se, bus.err_flag, bus.in_pkt);
    end
    @(negedge clk);
    n_checks++;
    if (bus.stuff_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse_width: got se=%b, want 0", bus.stuff_err);
    end
    for (int i = 0; i < 3; i++) begin
      send_dec(i[0], bv, bo, se);
      n_checks++;
      if (bv !== 1'b0 || se !== 1'b0) begin
        n_fail++;
        $display("FAIL err_ignore[%0d]: got bv=%b se=%b, want 0 0", i, bv, se);
      end
    end
    do_eop();
    n_checks++;
    if (bus.in_pkt !== 1'b0 || bus.err_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL err_eop: got ip=%b ef=%b, want 0 1", bus.in_pkt, bus.err_flag);
    end
    do_sync();
    n_checks++;
    if (bus.err_flag !== 1'b0 || bus.in_pkt !== 1'b1) begin
      n_fail++;
      $display("FAIL err_resync: got ef=%b ip=%b, want 0 1", bus.err_flag, bus.in_pkt);
    end
    do_eop();
  endtask

  task automatic test_nrzi();
    logic [4:0] raw;
    logic [4:0] exp;
    raw = 5'b01100;   // sent lsb first: 0,0,1,1,0
    exp = 5'b01010;   // decoded lsb first: 0,1,0,1,0
    lvl = 1'b1;
    do_sync();
    for (int i = 0; i < 5; i++) begin
      send_raw(raw[i], bv, bo, se);
      n_checks++;
      if (bv !== 1'b1 || bo !== exp[i]) begin
        n_fail++;
        $display("FAIL nrzi[%0d]: got bv=%b bo=%b, want 1 %b", i, bv, bo, exp[i]);
      end
    end
    do_eop();
  endtask

  task automatic test_counter_clear();
    logic [9:0] pat;
    pat = 10'b0111110111;   // lsb first: 1,1,1,0,1,1,1,1,1,0
    do_sync();
    for (int i = 0; i < 10; i++) begin
      send_dec(pat[i], bv, bo, se);
      n_checks++;
      if (bv !== 1'b1 || bo !== pat[i] || se !== 1'b0) begin
        n_fail++;
        $display("FAIL cnt_clear[%0d]: got bv=%b bo=%b se=%b, want 1 %b 0", i, bv, bo, se, pat[i]);
      end
    end
    do_eop();
  endtask

  task automatic test_eop_priority();
    do_sync();
    send_dec(1'b1, bv, bo, se);
    @(negedge clk);
    bus.line_in    = ~lvl;
    bus.line_valid = 1'b1;
    bus.pkt_done   = 1'b1;
    lvl            = ~lvl;
    @(negedge clk);
    bus.line_valid = 1'b0;
    bus.pkt_done   = 1'b0;
    n_checks++;
    if (bus.bit_valid !== 1'b0 || bus.in_pkt !== 1'b0 || bus.stuff_err !== 1'b0) begin
      n_fail++;
      $display("FAIL eop_priority: got bv=%b ip=%b se=%b, want 0 0 0",
               bus.bit_valid, bus.in_pkt, bus.stuff_err);
    end
    send_dec(1'b1, bv, bo, se);
    n_checks++;
    if (bv !== 1'b0) begin
      n_fail++;
      $display("FAIL eop_idle: got bv=%b, want 0", bv);
    end
  endtask

  task automatic test_async_reset();
    do_sync();
    @(negedge clk);
    bus.line_in    = lvl;
    bus.line_valid = 1'b1;
    @(posedge clk);
    #2;
    bus.line_valid = 1'b0;
    n_checks++;
    if (bus.bit_valid !== 1'b1 || bus.in_pkt !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: got bv=%b ip=%b, want 1 1", bus.bit_valid, bus.in_pkt);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.bit_valid !== 1'b0 || bus.in_pkt !== 1'b0 || bus.err_flag !== 1'b0 ||
        bus.bit_out !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_now: got bv=%b ip=%b ef=%b bo=%b, want 0 0 0 0",
               bus.bit_valid, bus.in_pkt, bus.err_flag, bus.bit_out);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_dec(1'b1, bv, bo, se);
      n_checks++;
      if (bv !== 1'b0 || bus.in_pkt !== 1'b0) begin
        n_fail++;
        $display("FAIL arst_ignore[%0d]: got bv=%b ip=%b, want 0 0", i, bv, bus.in_pkt);
      end
    end
    do_sync();
    send_dec(1'b0, bv, bo, se);
    n_checks++;
    if (bv !== 1'b1 || bo !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_resume: got bv=%b bo=%b, want 1 0", bv, bo);
    end
    do_eop();
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    lvl            = 1'b1;
    reset          = 1'b1;
    bus.line_in    = 1'b1;
    bus.line_valid = 1'b0;
    bus.sync_done  = 1'b0;
    bus.pkt_done   = 1'b0;
    test_reset();
    test_unstuff();
    test_stuff_error();
    test_nrzi();
    test_counter_clear();
    test_eop_priority();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_unstuff_down.md
Name: bit_unstuff_down

Overview:
- Receive-side counterpart of the upstream bit stuffer in the SIE.
- Takes sampled line bits, NRZI-decodes them, and strips the zero inserted after every STUFF_LEN consecutive ones.
- Flags a bit-stuff violation (a one in a stuff position) to the downstream packet decoder.
- Sits between the sync/EOP detector and the downstream shift register / CRC checkers.

Parameters:
- STUFF_LEN, 6, number of consecutive decoded ones after which the next bit is a stuffed zero.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- line_in  input  1  sampled line bit, NRZI-encoded (1 = J).
- line_valid  input  1  one-cycle strobe; line_in is a new bit-time sample.
- sync_done  input  1  one-cycle pulse, coincident with the line_valid of the final sync bit.
- pkt_done  input  1  one-cycle pulse on EOP detection.
- bit_out  output  1  decoded, unstuffed data bit.
- bit_valid  output  1  one-cycle strobe qualifying bit_out.
- stuff_err  output  1  one-cycle pulse on a stuffing violation.
- err_flag  output  1  sticky error; set with stuff_err, cleared at the next sync_done.
- in_pkt  output  1  high while in RECV or ERR.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, cnt = 0, prev_line = 1 (idle J).
  - bit_out, bit_valid, stuff_err, err_flag, in_pkt all 0.
- NRZI tracking:
  - On every line_valid, in every state, prev_line <= line_in.
  - Decoded bit d = ~(line_in ^ prev_line): no transition = 1, transition = 0.
- Counter:
  - cnt width is $clog2(STUFF_LEN+1).
  - Counts consecutive decoded ones; saturation is impossible by construction.
- States:
  - IDLE:
    - cnt held at 0; no outputs.
    - sync_done -> RECV, cnt <= 1 (final sync bit is a one and counts toward stuffing), err_flag <= 0.
    - The sync_done bit itself is not emitted.
  - RECV, on line_valid when cnt < STUFF_LEN:
    - bit_out <= d, bit_valid <= 1 next cycle.
    - cnt <= d ? cnt+1 : 0.
  - RECV, on line_valid when cnt == STUFF_LEN (stuff position):
    - d == 0: bit dropped, bit_valid stays 0, cnt <= 0.
    - d == 1: stuff_err pulses 1 cycle next cycle, err_flag <= 1, -> ERR, no bit_valid.
  - ERR:
    - All line_valid ignored; bit_valid held 0.
    - pkt_done -> IDLE.
- pkt_done in RECV or ERR:
  - -> IDLE, cnt <= 0.
  - pkt_done has priority over a simultaneous line_valid: that bit is not emitted and not checked.
  - prev_line still updates on that sample.
- sync_done while in RECV or ERR: restart. Go to RECV with cnt <= 1 and err_flag <= 0 (resync wins).
- Timing and outputs:
  - Latency is exactly 1 clk from line_valid to bit_valid / stuff_err. All outputs registered.
  - bit_valid is never asserted in consecutive cycles unless line_valid was.
  - in_pkt = (state != IDLE), registered with the state.
  - bit_out holds its last value when bit_valid = 0.
- Reset asserted mid-packet: everything returns to reset values immediately; no partial bit emitted.

Test Plan:
1. Data-ones unstuffing:
   - Stimulus: after sync_done, line samples decoding to 1,1,1,1,1 (5 ones; 6 with the sync one), then stuffed 0, then 1.
   - Required: bit_valid pulses 6 times with bits 1,1,1,1,1,1. Wait: cnt starts at 1, so after 5 data ones cnt = 6 and the 0 is dropped.
   - Exact emitted stream: 1,1,1,1,1, then 1. Emitted count is 6, never 7.
2. Stuff error:
   - Stimulus: sync_done, then 5 decoded ones, then a decoded 1 in the stuff position.
   - Required: 5 bit_valid pulses, stuff_err for one cycle, err_flag = 1, in_pkt = 1.
   - Subsequent samples produce no bit_valid. pkt_done -> in_pkt = 0, err_flag still 1.
   - Next sync_done clears err_flag.
3. NRZI decode:
   - Stimulus: line 1 (sync end), then 0,0,1,1,0.
   - Required: bit_out stream 0,1,0,1,0, each one clk after its line_valid.
4. Counter reset by zero:
   - Stimulus: decoded 1,1,1,0,1,1,1,1,1,0.
   - Required: all 10 bits emitted. No drop, because the run is broken before reaching 6.
5. EOP priority:
   - Stimulus: pkt_done coincident with line_valid.
   - Required: no bit_valid, state IDLE, in_pkt = 0 on the next cycle.
6. Async reset:
   - Stimulus: reset asserted mid-packet, between clk edges.
   - Required: bit_valid, in_pkt, err_flag go 0 immediately; prev_line = 1.
   - After release, line samples are ignored until sync_done.
